// File: rtl/pc_call_stack.sv
// pc_call_stack
//   Program counter with signed relative branching and a return-address
//   stack for call/return. The PC goes to the shared bus through an
//   explicit output enable rather than a tri-state driver.
//
// Parameters
//   WIDTH     : PC, bus and stack-entry width (>= 2)
//   DEPTH     : number of return-stack entries (>= 1)
//   RESET_VEC : PC value after reset
//
// Ports
//   clk         : system clock, rising edge
//   clr_n       : asynchronous active-low reset
//   lp          : load pc from bus_in
//   cp          : increment pc
//   ep          : drive pc onto bus_out / assert bus_oe
//   call        : push pc+1, load pc from bus_in
//   ret         : pop top of stack into pc
//   rel         : pc <= pc + signed(bus_in)
//   bus_in      : bus data for load/call/rel
//   bus_out     : ep ? pc : 0
//   bus_oe      : equals ep
//   pc          : current program counter
//   sp          : number of valid stack entries, 0..DEPTH
//   stack_empty : sp == 0
//   stack_full  : sp == DEPTH
//   fault       : sticky overflow/underflow flag, cleared only by reset
module pc_call_stack #(
  parameter int               WIDTH     = 4,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic                       clk,
  input  logic                       clr_n,
  input  logic                       lp,
  input  logic                       cp,
  input  logic                       ep,
  input  logic                       call,
  input  logic                       ret,
  input  logic                       rel,
  input  logic [WIDTH-1:0]           bus_in,
  output logic [WIDTH-1:0]           bus_out,
  output logic                       bus_oe,
  output logic [WIDTH-1:0]           pc,
  output logic [$clog2(DEPTH+1)-1:0] sp,
  output logic                       stack_empty,
  output logic                       stack_full,
  output logic                       fault
);

  localparam int SPW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] pc_q;
  logic [SPW-1:0]   sp_q;
  logic             fault_q;
  logic [WIDTH-1:0] stack_q [DEPTH];

  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] pc_rel;
  logic [WIDTH-1:0] top_entry;
  logic             empty;
  logic             full;

  assign pc_inc = pc_q + WIDTH'(1);
  // Adding bus_in at full width modulo 2^WIDTH is identical to adding its
  // sign extension and discarding the carry, so no explicit extension needed.
  assign pc_rel = pc_q + bus_in;

  assign empty = (sp_q == '0);
  assign full  = (sp_q == SPW'(DEPTH));

  // Top-of-stack mux decoded by compare so sp never indexes the array
  // directly; slots at or above sp are never selected.
  always_comb begin
    top_entry = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sp_q == SPW'(i + 1)) top_entry = stack_q[i];
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pc_q    <= RESET_VEC;
      sp_q    <= '0;
      fault_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else if (ret) begin
      if (empty) begin
        fault_q <= 1'b1;
      end else begin
        pc_q <= top_entry;
        sp_q <= sp_q - SPW'(1);
      end
    end else if (call) begin
      if (full) begin
        fault_q <= 1'b1;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (sp_q == SPW'(i)) stack_q[i] <= pc_inc;
        end
        sp_q <= sp_q + SPW'(1);
        pc_q <= bus_in;
      end
    end else if (rel) begin
      pc_q <= pc_rel;
    end else if (lp) begin
      pc_q <= bus_in;
    end else if (cp) begin
      pc_q <= pc_inc;
    end
  end

  assign pc          = pc_q;
  assign sp          = sp_q;
  assign fault       = fault_q;
  assign stack_empty = empty;
  assign stack_full  = full;
  assign bus_oe      = ep;
  assign bus_out     = ep ? pc_q : '0;

endmodule

// File: tb/tb_pc_call_stack.sv
module tb_pc_call_stack;

  logic       clk;
  logic       clr_n;
  logic       lp, cp, ep, call, ret, rel;
  logic [3:0] bus_in;
  logic [3:0] bus_out;
  logic       bus_oe;
  logic [3:0] pc;
  logic [2:0] sp;
  logic       stack_empty, stack_full, fault;

  int vectors;
  int miscompares;

  pc_call_stack #(.WIDTH(4), .DEPTH(4), .RESET_VEC(4'd0)) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .lp          (lp),
    .cp          (cp),
    .ep          (ep),
    .call        (call),
    .ret         (ret),
    .rel         (rel),
    .bus_in      (bus_in),
    .bus_out     (bus_out),
    .bus_oe      (bus_oe),
    .pc          (pc),
    .sp          (sp),
    .stack_empty (stack_empty),
    .stack_full  (stack_full),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one command for one rising edge, then release the strobes.
  // Returns 1 ns after the edge so outputs are sampled away from it.
  task automatic do_cycle(input bit r, input bit c, input bit rl,
                          input bit l, input bit p, input logic [3:0] b);
    ret = r; call = c; rel = rl; lp = l; cp = p; bus_in = b;
    @(posedge clk);
    #1;
    ret = 0; call = 0; rel = 0; lp = 0; cp = 0; bus_in = 4'd0;
  endtask

  task automatic do_reset();
    clr_n = 1'b0;
    #2;
    clr_n = 1'b1;
  endtask

  task automatic test_reset();
    ep = 1'b0;
    clr_n = 1'b0;
    #3;
    vectors++;
    if (pc !== 4'd0) begin miscompares++; $display("FAIL reset_pc got %0d want 0", pc); end
    vectors++;
    if (sp !== 3'd0) begin miscompares++; $display("FAIL reset_sp got %0d want 0", sp); end
    vectors++;
    if (fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault got %b want 0", fault); end
    vectors++;
    if (stack_empty !== 1'b1 || stack_full !== 1'b0) begin
      miscompares++; $display("FAIL reset_flags got empty=%b full=%b want 1 0", stack_empty, stack_full);
    end
    vectors++;
    if (bus_out !== 4'd0 || bus_oe !== 1'b0) begin
      miscompares++; $display("FAIL reset_bus got %0d oe=%b want 0 0", bus_out, bus_oe);
    end
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  task automatic test_count();
    logic [3:0] exp;
    do_reset();
    ep = 1'b1;
    exp = 4'd0;
    for (int i = 0; i < 17; i++) begin
      // bus shows the pre-edge pc while the command is pending
      cp = 1'b1;
      #1;
      vectors++;
      if (bus_out !== exp || bus_oe !== 1'b1) begin
        miscompares++; $display("FAIL count_bus_pre step %0d got %0d oe=%b want %0d 1", i, bus_out, bus_oe, exp);
      end
      do_cycle(0, 0, 0, 0, 1, 4'd0);
      exp = exp + 4'd1;
      vectors++;
      if (pc !== exp) begin miscompares++; $display("FAIL count_pc step %0d got %0d want %0d", i, pc, exp); end
    end
    vectors++;
    if (pc !== 4'd1) begin miscompares++; $display("FAIL count_wrap got %0d want 1", pc); end
    ep = 1'b0;
    #1;
    vectors++;
    if (bus_out !== 4'd0 || bus_oe !== 1'b0) begin
      miscompares++; $display("FAIL count_ep_off got %0d oe=%b want 0 0", bus_out, bus_oe);
    end
  endtask

  task automatic test_rel();
    do_cycle(0, 0, 0, 1, 0, 4'd5);
    do_cycle(0, 0, 1, 0, 0, 4'hD);
    vectors++;
    if (pc !== 4'd2) begin miscompares++; $display("FAIL rel_neg got %0d want 2", pc); end
    do_cycle(0, 0, 0, 1, 0, 4'd14);
    do_cycle(0, 0, 1, 0, 0, 4'd3);
    vectors++;
    if (pc !== 4'd1) begin miscompares++; $display("FAIL rel_wrap got %0d want 1", pc); end
  endtask

  task automatic test_call_ret();
    do_reset();
    do_cycle(0, 0, 0, 1, 0, 4'd3);
    do_cycle(0, 1, 0, 0, 0, 4'd9);
    vectors++;
    if (pc !== 4'd9 || sp !== 3'd1) begin miscompares++; $display("FAIL call1 got pc=%0d sp=%0d want 9 1", pc, sp); end
    do_cycle(0, 1, 0, 0, 0, 4'd12);
    vectors++;
    if (pc !== 4'd12 || sp !== 3'd2) begin miscompares++; $display("FAIL call2 got pc=%0d sp=%0d want 12 2", pc, sp); end
    do_cycle(1, 0, 0, 0, 0, 4'd0);
    vectors++;
    if (pc !== 4'd10 || sp !== 3'd1) begin miscompares++; $display("FAIL ret1 got pc=%0d sp=%0d want 10 1", pc, sp); end
    do_cycle(1, 0, 0, 0, 0, 4'd0);
    vectors++;
    if (pc !== 4'd4 || sp !== 3'd0 || stack_empty !== 1'b1) begin
      miscompares++; $display("FAIL ret2 got pc=%0d sp=%0d empty=%b want 4 0 1", pc, sp, stack_empty);
    end
    vectors++;
    if (fault !== 1'b0) begin miscompares++; $display("FAIL call_ret_fault got %b want 0", fault); end
  endtask

  task automatic test_overflow();
    logic [3:0] targets [4];
    logic [3:0] rets [4];
    targets = '{4'd8, 4'd10, 4'd12, 4'd14};
    rets    = '{4'd13, 4'd11, 4'd9, 4'd1};
    do_reset();
    for (int i = 0; i < 4; i++) do_cycle(0, 1, 0, 0, 0, targets[i]);
    vectors++;
    if (sp !== 3'd4 || stack_full !== 1'b1 || pc !== 4'd14) begin
      miscompares++; $display("FAIL ovf_fill got sp=%0d full=%b pc=%0d want 4 1 14", sp, stack_full, pc);
    end
    do_cycle(0, 1, 0, 0, 0, 4'd7);
    vectors++;
    if (pc !== 4'd14 || sp !== 3'd4 || fault !== 1'b1) begin
      miscompares++; $display("FAIL ovf_call got pc=%0d sp=%0d fault=%b want 14 4 1", pc, sp, fault);
    end
    for (int i = 0; i < 4; i++) begin
      do_cycle(1, 0, 0, 0, 0, 4'd0);
      vectors++;
      if (pc !== rets[i] || sp !== 3'(3 - i)) begin
        miscompares++; $display("FAIL ovf_ret%0d got pc=%0d sp=%0d want %0d %0d", i, pc, sp, rets[i], 3 - i);
      end
    end
  endtask

  task automatic test_underflow();
    do_reset();
    do_cycle(1, 0, 0, 0, 0, 4'd0);
    vectors++;
    if (pc !== 4'd0 || sp !== 3'd0 || fault !== 1'b1) begin
      miscompares++; $display("FAIL unf_ret got pc=%0d sp=%0d fault=%b want 0 0 1", pc, sp, fault);
    end
    do_cycle(0, 0, 0, 1, 0, 4'd6);
    vectors++;
    if (pc !== 4'd6 || fault !== 1'b1) begin
      miscompares++; $display("FAIL unf_lp got pc=%0d fault=%b want 6 1", pc, fault);
    end
  endtask

  task automatic test_priority();
    do_reset();
    do_cycle(0, 0, 0, 1, 0, 4'd2);
    do_cycle(0, 1, 0, 0, 0, 4'd9);
    do_cycle(1, 1, 1, 1, 1, 4'd5);
    vectors++;
    if (pc !== 4'd3 || sp !== 3'd0) begin miscompares++; $display("FAIL prio_ret got pc=%0d sp=%0d want 3 0", pc, sp); end
    do_cycle(0, 1, 1, 1, 1, 4'd5);
    vectors++;
    if (pc !== 4'd5 || sp !== 3'd1) begin miscompares++; $display("FAIL prio_call got pc=%0d sp=%0d want 5 1", pc, sp); end
    do_cycle(0, 0, 1, 1, 1, 4'd2);
    vectors++;
    if (pc !== 4'd7) begin miscompares++; $display("FAIL prio_rel got pc=%0d want 7", pc); end
    do_cycle(0, 0, 0, 1, 1, 4'd2);
    vectors++;
    if (pc !== 4'd2) begin miscompares++; $display("FAIL prio_lp got pc=%0d want 2", pc); end
    do_cycle(1, 0, 0, 0, 0, 4'd0);
    vectors++;
    if (pc !== 4'd4 || sp !== 3'd0) begin miscompares++; $display("FAIL prio_pop got pc=%0d sp=%0d want 4 0", pc, sp); end
    do_cycle(1, 0, 0, 0, 0, 4'd0);
    do_cycle(0, 1, 0, 0, 0, 4'd11);
    vectors++;
    if (fault !== 1'b1 || sp !== 3'd1 || pc !== 4'd11) begin
      miscompares++; $display("FAIL prio_setup got fault=%b sp=%0d pc=%0d want 1 1 11", fault, sp, pc);
    end
    // Reset between edges must clear immediately.
    #2;
    clr_n = 1'b0;
    #1;
    vectors++;
    if (pc !== 4'd0 || sp !== 3'd0 || fault !== 1'b0) begin
      miscompares++; $display("FAIL async_reset got pc=%0d sp=%0d fault=%b want 0 0 0", pc, sp, fault);
    end
    @(negedge clk);
    clr_n = 1'b1;
    // Popping after reset must not resurrect the pre-reset entry.
    do_cycle(1, 0, 0, 0, 0, 4'd0);
    vectors++;
    if (pc !== 4'd0 || sp !== 3'd0) begin miscompares++; $display("FAIL post_reset_ret got pc=%0d sp=%0d want 0 0", pc, sp); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    do_cycle(0, 1, 0, 0, 0, 4'd6);
    vectors++;
    if (pc !== 4'd6 || sp !== 3'd1) begin miscompares++; $display("FAIL b2b_call1 got pc=%0d sp=%0d want 6 1", pc, sp); end
    do_cycle(1, 0, 0, 0, 0, 4'd0);
    vectors++;
    if (pc !== 4'd1 || sp !== 3'd0) begin miscompares++; $display("FAIL b2b_ret1 got pc=%0d sp=%0d want 1 0", pc, sp); end
    do_cycle(0, 1, 0, 0, 0, 4'd9);
    do_cycle(0, 1, 0, 0, 0, 4'd3);
    vectors++;
    if (pc !== 4'd3 || sp !== 3'd2) begin miscompares++; $display("FAIL b2b_call3 got pc=%0d sp=%0d want 3 2", pc, sp); end
    do_cycle(1, 0, 0, 0, 0, 4'd0);
    vectors++;
    if (pc !== 4'd10 || sp !== 3'd1) begin miscompares++; $display("FAIL b2b_ret2 got pc=%0d sp=%0d want 10 1", pc, sp); end
    do_cycle(1, 0, 0, 0, 0, 4'd0);
    vectors++;
    if (pc !== 4'd2 || sp !== 3'd0 || fault !== 1'b0) begin
      miscompares++; $display("FAIL b2b_ret3 got pc=%0d sp=%0d fault=%b want 2 0 0", pc, sp, fault);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    clr_n = 1'b0;
    lp = 0; cp = 0; ep = 0; call = 0; ret = 0; rel = 0;
    bus_in = 4'd0;
    test_reset();
    test_count();
    test_rel();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_priority();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_call_stack.md
# pc_call_stack

Parametrised program counter with an integrated return-address stack for the 8-bit CPU core. It extends the basic counter (clear, load, count, bus enable) to arbitrary width, adds signed relative branching, and adds call/return with a hardware stack of configurable depth plus full/empty/fault status. It sits between the control sequencer, which drives the one-hot-ish command strobes, and the shared bus, which it drives through an explicit output-enable rather than a tri-state.

## Interface
- `WIDTH`, 4: PC, bus and stack-entry width in bits (≥2).
- `DEPTH`, 4: return-stack entries (≥1).
- `RESET_VEC`, 0: PC value after reset, WIDTH bits.

- `clk` in 1: clock. All state updates on the rising edge.
- `clr_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `lp` in 1: load PC from `bus_in`.
- `cp` in 1: increment PC.
- `ep` in 1: enable PC onto bus.
- `call` in 1: push PC+1, load PC from `bus_in`.
- `ret` in 1: pop top of stack into PC.
- `rel` in 1: PC ← PC + signed(`bus_in`).
- `bus_in` in WIDTH: bus data for load/call/rel.
- `bus_out` out WIDTH: `ep ? pc : 0`.
- `bus_oe` out 1: equals `ep`.
- `pc` out WIDTH: current PC.
- `sp` out clog2(DEPTH+1): number of valid stack entries, 0..DEPTH.
- `stack_empty` out 1: `sp == 0`.
- `stack_full` out 1: `sp == DEPTH`.
- `fault` out 1: sticky overflow/underflow flag.

## Operation
- Reset (`clr_n`=0): pc=RESET_VEC, sp=0, fault=0, all stack entries=0; `bus_out`=0 while `ep`=0.
- Per cycle exactly one command executes, priority ret > call > rel > lp > cp; lower ones ignored that cycle. None asserted: hold.
- cp: pc ← pc+1 mod 2^WIDTH (all-ones wraps to 0).
- lp: pc ← bus_in.
- rel: pc ← (pc + sign-extended bus_in) mod 2^WIDTH; bus_in MSB is sign. Carry/borrow discarded.
- call, not full: stack[sp] ← pc+1 mod 2^WIDTH; sp ← sp+1; pc ← bus_in.
- call, full: no push, pc and sp unchanged, fault ← 1.
- ret, not empty: pc ← stack[sp-1]; sp ← sp-1.
- ret, empty: pc and sp unchanged, fault ← 1.
- fault is cleared only by reset; it does not block further commands.
- `ep` is independent of all commands: bus shows the pre-edge pc in the same cycle a command updates it.
- Stack is LIFO, no wrap; entries above sp are don't-care but must not be readable via ret.

## Timing
- Single-cycle: command sampled at rising edge, new pc/sp/fault visible after that edge.
- `bus_out`, `bus_oe`, `stack_empty`, `stack_full` combinational from `ep`, pc, sp; no added latency.
- Back-to-back call/ret in consecutive cycles supported at full rate.
- Reset asserted mid-cycle clears state immediately, irrespective of `clk`; deassertion is synchronised externally.
- No X on any output after reset for any command sequence.

## Test plan (WIDTH=4, DEPTH=4, RESET_VEC=0)
- Reset then cp for 17 cycles -> pc 1,2,…,15,0,1; ep=1 shows pc on `bus_out`, ep=0 gives 0 and `bus_oe`=0.
- pc=5, rel with bus_in=4'hD (−3) -> pc=2; pc=14, rel bus_in=3 -> pc=1 (wrap).
- pc=3, call bus_in=9 -> pc=9, sp=1; call bus_in=12 -> pc=12, sp=2; ret -> pc=10, sp=1; ret -> pc=4, sp=0, stack_empty=1.
- Four calls -> sp=4, stack_full=1; fifth call bus_in=7 -> pc unchanged, sp=4, fault=1; four rets return addresses in reverse order.
- From reset, ret -> pc=0, sp=0, fault=1; then lp bus_in=6 -> pc=6, fault stays 1.
- lp+cp+rel+call+ret asserted together with stack non-empty -> only pop occurs; assert clr_n=0 between edges -> pc=0, sp=0, fault=0 immediately.
